// File: rtl/ofm_accum_pack.sv
// Accumulates ACC_LEN partial sums per output pixel, requantises each pixel to 4 bits
// and packs 32 pixels per 128-bit word into a 2-entry output FIFO.
module ofm_accum_pack #(
    parameter int ACC_LEN = 4,
    parameter int SHIFT   = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [12:0]  In_PSum,
    input  logic         flush,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [127:0] Out_Word,
    output logic [5:0]   Out_Count,
    output logic         overflow
);

    typedef enum logic [1:0] {EMPTY, PART, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [16:0]   acc;
    logic [3:0]    psum_cnt;
    logic [4:0]    pix_cnt;
    logic [127:0]  pack;

    logic [16:0]   acc_sum, acc_1;
    logic [3:0]    psum_1;
    logic [4:0]    pix_1;
    logic [127:0]  pack_1;
    logic          word_done, flush_push, pending_1, push;
    logic [127:0]  push_word;
    logic [5:0]    push_count;

    logic [127:0]  fifo_word [2];
    logic [5:0]    fifo_count [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    fifo_cnt;
    logic          pop, accept;

    // Round-to-nearest right shift, saturated to a nibble; 18 bits avoids carry loss.
    function automatic logic [3:0] requant(input logic [16:0] a);
        logic [17:0] r;
        r = {1'b0, a} + 18'(1 << (SHIFT - 1));
        r = r >> SHIFT;
        return (r > 18'd15) ? 4'hF : r[3:0];
    endfunction

    // The psum is applied first; any flush then acts on the post-psum state.
    always_comb begin
        acc_sum   = (psum_cnt == 4'd0 ? 17'd0 : acc) + 17'(In_PSum);
        acc_1     = acc;
        psum_1    = psum_cnt;
        pix_1     = pix_cnt;
        pack_1    = pack;
        word_done = 1'b0;
        if (in_valid) begin
            acc_1 = acc_sum;
            if (psum_cnt == 4'(ACC_LEN - 1)) begin
                psum_1 = 4'd0;
                pack_1[{pix_cnt, 2'b00} +: 4] = requant(acc_sum);
                pix_1 = pix_cnt + 5'd1;
                word_done = (pix_cnt == 5'd31);
            end else begin
                psum_1 = psum_cnt + 4'd1;
            end
        end
        pending_1  = (psum_1 != 4'd0) || (pix_1 != 5'd0);
        flush_push = flush && !word_done && pending_1;
        push_word  = pack_1;
        push_count = 6'd32;
        if (flush_push) begin
            if (psum_1 != 4'd0) begin
                push_word[{pix_1, 2'b00} +: 4] = requant(acc_1);
                push_count = {1'b0, pix_1} + 6'd1;
            end else begin
                push_count = {1'b0, pix_1};
            end
        end
        push = word_done || flush_push;
    end

    // FLUSH is the cycle in which the padded word becomes visible; a psum arriving then opens new data.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (flush_push)                   state_nxt = FLUSH;
                else if (in_valid && !word_done)  state_nxt = PART;
            end
            PART: begin
                if (flush_push)                   state_nxt = FLUSH;
                else if (word_done)               state_nxt = EMPTY;
            end
            FLUSH: begin
                if (flush_push)                   state_nxt = FLUSH;
                else if (in_valid && !word_done)  state_nxt = PART;
                else                              state_nxt = EMPTY;
            end
            default:                              state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= EMPTY;
            acc      <= '0;
            psum_cnt <= '0;
            pix_cnt  <= '0;
            pack     <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_1;
            if (push) begin
                psum_cnt <= '0;
                pix_cnt  <= '0;
                pack     <= '0;
            end else begin
                psum_cnt <= psum_1;
                pix_cnt  <= pix_1;
                pack     <= pack_1;
            end
        end
    end

    // A push into a full FIFO succeeds only when the head leaves on the same edge.
    assign pop    = (fifo_cnt != 2'd0) && out_ready;
    assign accept = push && ((fifo_cnt != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_word[i]  <= '0;
                fifo_count[i] <= '0;
            end
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                fifo_word[wr_ptr]  <= push_word;
                fifo_count[wr_ptr] <= push_count;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(accept) - 2'(pop);
            if (push && !accept)
                overflow <= 1'b1;
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign Out_Word  = out_valid ? fifo_word[rd_ptr] : '0;
    assign Out_Count = out_valid ? fifo_count[rd_ptr] : '0;

endmodule

// File: tb/tb_ofm_accum_pack.sv
// Self-checking bench for ofm_accum_pack: directed scenarios plus a randomized run
// compared against a list-based model of pixels, words and the 2-deep output queue.
module tb_ofm_accum_pack;

    localparam int ACC_LEN = 4;
    localparam int SHIFT   = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [12:0]  in_psum = '0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [127:0] out_word;
    logic [5:0]   out_count;
    logic         overflow;

    int n_cmp = 0;
    int n_fail = 0;

    int           cur_ps[$];
    logic [3:0]   pix[$];
    logic [127:0] mq_word[$];
    logic [5:0]   mq_cnt[$];
    logic         m_ovf = 1'b0;

    ofm_accum_pack #(.ACC_LEN(ACC_LEN), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .In_PSum(in_psum),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .Out_Word(out_word), .Out_Count(out_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_nibble(input int sum);
        int r;
        r = (sum + (1 << (SHIFT - 1))) / (1 << SHIFT);
        return (r > 15) ? 4'hF : 4'(r);
    endfunction

    function automatic int pixel_total();
        int s = 0;
        foreach (cur_ps[i]) s += cur_ps[i];
        return s;
    endfunction

    function automatic logic [127:0] pack_pixels();
        logic [127:0] w = '0;
        foreach (pix[k]) w[4*k +: 4] = pix[k];
        return w;
    endfunction

    task automatic model_push(input logic [127:0] w, input logic [5:0] c);
        if (mq_word.size() < 2) begin
            mq_word.push_back(w);
            mq_cnt.push_back(c);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    // One clock edge of the reference behaviour: pop, then psum, then flush.
    task automatic model_edge(input bit iv, input int ps, input bit fl, input bit rdy);
        bit word_done = 1'b0;
        if (mq_word.size() != 0 && rdy) begin
            void'(mq_word.pop_front());
            void'(mq_cnt.pop_front());
        end
        if (iv) begin
            cur_ps.push_back(ps);
            if (cur_ps.size() == ACC_LEN) begin
                pix.push_back(ref_nibble(pixel_total()));
                cur_ps.delete();
                if (pix.size() == 32) begin
                    model_push(pack_pixels(), 6'd32);
                    pix.delete();
                    word_done = 1'b1;
                end
            end
        end
        if (fl && !word_done && (cur_ps.size() != 0 || pix.size() != 0)) begin
            if (cur_ps.size() != 0) begin
                pix.push_back(ref_nibble(pixel_total()));
                cur_ps.delete();
            end
            model_push(pack_pixels(), 6'(pix.size()));
            pix.delete();
        end
    endtask

    task automatic tick(input bit iv, input int ps, input bit fl, input bit rdy);
        in_valid  = iv;
        in_psum   = 13'(ps);
        flush     = fl;
        out_ready = rdy;
        @(posedge clk);
        model_edge(iv, ps, fl, rdy);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (n) @(posedge clk);
        cur_ps.delete();
        pix.delete();
        mq_word.delete();
        mq_cnt.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        tick(0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_word !== 128'h0) begin n_fail++; $display("[TB] FAIL reset_out_word: got %h expected 0", out_word); end
        n_cmp++; if (out_count !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_out_count: got %0d expected 0", out_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_full_word(input int value, input logic [3:0] nib);
        logic [127:0] exp_word;
        exp_word = {32{nib}};
        do_reset(2);
        for (int i = 0; i < 127; i++) tick(1, value, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_early_valid: got %b expected 0", out_valid); end
        tick(1, value, 0, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_latency_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_word !== exp_word) begin n_fail++; $display("[TB] FAIL full_word: got %h expected %h", out_word, exp_word); end
        n_cmp++; if (out_count !== 6'd32) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected 32", out_count); end
        n_cmp++; if (mq_word.size() == 0 || out_word !== mq_word[0]) begin n_fail++; $display("[TB] FAIL full_word_model: got %h model entries %0d", out_word, mq_word.size()); end
        tick(0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_single_cycle: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset(2);
        for (int i = 0; i < 20; i++) tick(1, 64, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_pre_valid: got %b expected 0", out_valid); end
        tick(0, 0, 1, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_valid: got %b expected 1", out_valid); end
        n_cmp++; if (out_word !== 128'h44444) begin n_fail++; $display("[TB] FAIL flush_word: got %h expected 44444", out_word); end
        n_cmp++; if (out_count !== 6'd5) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 5", out_count); end
        tick(0, 0, 0, 1);
        tick(0, 0, 1, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty_noop: got %b expected 0", out_valid); end
        tick(0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_empty_noop_late: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        for (int i = 0; i < 3; i++) tick(1, 1000, 0, 1);
        tick(1, 1000, 1, 1);
        n_cmp++; if (out_valid !== 1'b1 || out_count !== 6'd1) begin n_fail++; $display("[TB] FAIL b2b_first_count: got valid %b count %0d expected 1/1", out_valid, out_count); end
        n_cmp++; if (out_word !== 128'hF) begin n_fail++; $display("[TB] FAIL b2b_first_word: got %h expected f", out_word); end
        for (int i = 0; i < 4; i++) tick(1, 200, 0, 1);
        tick(0, 0, 1, 1);
        n_cmp++; if (out_valid !== 1'b1 || out_count !== 6'd1) begin n_fail++; $display("[TB] FAIL b2b_second_count: got valid %b count %0d expected 1/1", out_valid, out_count); end
        n_cmp++; if (out_word !== 128'hD) begin n_fail++; $display("[TB] FAIL b2b_second_word: got %h expected d", out_word); end
        tick(0, 0, 0, 1);
    endtask

    task automatic test_overflow();
        do_reset(2);
        for (int i = 0; i < 3 * 128; i++) tick(1, int'($urandom_range(0, 8191)), 0, 0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        n_cmp++; if (mq_word.size() != 2 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_depth: got valid %b model entries %0d expected 1/2", out_valid, mq_word.size()); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (mq_word.size() == 0 || out_word !== mq_word[0] || out_count !== mq_cnt[0]) begin
                n_fail++; $display("[TB] FAIL ovf_drain_%0d: got %h/%0d model entries %0d", k, out_word, out_count, mq_word.size());
            end
            tick(0, 0, 0, 1);
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_drained: got %b expected 0", out_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        for (int i = 0; i < 10; i++) tick(1, int'($urandom_range(0, 8191)), 0, 1);
        do_reset(2);
        for (int i = 0; i < 127; i++) tick(1, 100, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_residue: got %b expected 0", out_valid); end
        tick(1, 100, 0, 1);
        n_cmp++; if (out_valid !== 1'b1 || out_word !== {32{4'h6}}) begin n_fail++; $display("[TB] FAIL rstmid_word: got %b/%h expected all 6", out_valid, out_word); end
        tick(0, 0, 0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_single: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        bit iv, fl, rdy;
        int ps;
        do_reset(2);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            iv  = ($urandom_range(0, 3) != 0);
            ps  = int'($urandom_range(0, 8191) >> $urandom_range(0, 8));
            fl  = ($urandom_range(0, 40) == 0);
            rdy = ((cyc / 300) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick(iv, ps, fl, rdy);
            n_cmp++;
            if (out_valid !== (mq_word.size() != 0)) begin
                n_fail++; $display("[TB] FAIL rand_valid@%0d: got %b model entries %0d", cyc, out_valid, mq_word.size());
            end else if (mq_word.size() != 0 && (out_word !== mq_word[0] || out_count !== mq_cnt[0])) begin
                n_fail++; $display("[TB] FAIL rand_head@%0d: got %h/%0d expected %h/%0d", cyc, out_word, out_count, mq_word[0], mq_cnt[0]);
            end
            n_cmp++;
            if (overflow !== m_ovf) begin
                n_fail++; $display("[TB] FAIL rand_overflow@%0d: got %b expected %b", cyc, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word(100, 4'h6);
        test_full_word(8191, 4'hF);
        test_flush();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
